// File: rtl/gcd_engine.sv
// Iterative GCD coprocessor: one reduction step per clock, subtractive Euclid
// (MODE 0) or binary Stein (MODE 1), with a saturating step counter.
module gcd_engine #(
    parameter int WIDTH  = 16,
    parameter int MODE   = 0,
    parameter int ITER_W = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WIDTH-1:0]  Result,
    output logic [ITER_W-1:0] Iters,
    output logic              Busy
);

    // k counts the common factors of two removed by Stein; it never exceeds WIDTH-1.
    localparam int K_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   ra_next;
    logic [WIDTH-1:0]   rb_next;
    logic [K_W-1:0]     k_next;
    logic [WIDTH-1:0]   result_next;
    logic [ITER_W-1:0]  iters_next;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ra_next     = ra;
        rb_next     = rb;
        k_next      = k;
        result_next = Result;
        iters_next  = Iters;
        InReady     = (state == IDLE);
        OutValid    = (state == DONE);
        Busy        = (state == CALC);

        case (state)
            IDLE: begin
                if (InValid) begin
                    ra_next    = A;
                    rb_next    = B;
                    k_next     = '0;
                    iters_next = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (ra == '0) begin
                    result_next = rb << k;
                    state_next  = DONE;
                end else if (rb == '0) begin
                    result_next = ra << k;
                    state_next  = DONE;
                end else if (ra == rb) begin
                    result_next = ra << k;
                    state_next  = DONE;
                end else begin
                    iters_next = (&Iters) ? Iters : Iters + 1'b1;
                    if (MODE == 1 && !ra[0] && !rb[0]) begin
                        ra_next = ra >> 1;
                        rb_next = rb >> 1;
                        k_next  = k + 1'b1;
                    end else if (MODE == 1 && !ra[0]) begin
                        ra_next = ra >> 1;
                    end else if (MODE == 1 && !rb[0]) begin
                        rb_next = rb >> 1;
                    end else if (ra > rb) begin
                        ra_next = ra - rb;
                    end else begin
                        rb_next = rb - ra;
                    end
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result and Iters are only rewritten by the datapath, so they hold through IDLE.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ra     <= '0;
            rb     <= '0;
            k      <= '0;
            Result <= '0;
            Iters  <= '0;
        end else begin
            ra     <= ra_next;
            rb     <= rb_next;
            k      <= k_next;
            Result <= result_next;
            Iters  <= iters_next;
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: Euclid, Stein and a 4-bit-counter Euclid
// instance exercised side by side on a shared clock and reset.
module tb_gcd_engine;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        in_valid [3];
    logic        out_ready [3];
    logic        in_ready [3];
    logic        out_valid [3];
    logic        busy [3];
    logic [15:0] result [3];
    logic [15:0] iters [2];
    logic [3:0]  iters_sat;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    typedef struct {
        logic [15:0] result;
        logic [15:0] iters;
        int          steps;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    gcd_engine #(.WIDTH(16), .MODE(0), .ITER_W(16)) dut_euclid (
        .CLK(CLK), .reset(reset), .InValid(in_valid[0]), .InReady(in_ready[0]),
        .A(a_in), .B(b_in), .OutValid(out_valid[0]), .OutReady(out_ready[0]),
        .Result(result[0]), .Iters(iters[0]), .Busy(busy[0])
    );

    gcd_engine #(.WIDTH(16), .MODE(1), .ITER_W(16)) dut_stein (
        .CLK(CLK), .reset(reset), .InValid(in_valid[1]), .InReady(in_ready[1]),
        .A(a_in), .B(b_in), .OutValid(out_valid[1]), .OutReady(out_ready[1]),
        .Result(result[1]), .Iters(iters[1]), .Busy(busy[1])
    );

    gcd_engine #(.WIDTH(16), .MODE(0), .ITER_W(4)) dut_sat (
        .CLK(CLK), .reset(reset), .InValid(in_valid[2]), .InReady(in_ready[2]),
        .A(a_in), .B(b_in), .OutValid(out_valid[2]), .OutReady(out_ready[2]),
        .Result(result[2]), .Iters(iters_sat), .Busy(busy[2])
    );

    function automatic logic [15:0] model_gcd(input int unsigned x, input int unsigned y);
        int unsigned p;
        int unsigned q;
        int unsigned t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p[15:0];
    endfunction

    function automatic int model_steps(input int unsigned x, input int unsigned y, input int mode);
        int n;
        n = 0;
        while (x != 0 && y != 0 && x != y) begin
            if (mode == 1 && x[0] == 1'b0 && y[0] == 1'b0) begin
                x = x / 2;
                y = y / 2;
            end else if (mode == 1 && x[0] == 1'b0) begin
                x = x / 2;
            end else if (mode == 1 && y[0] == 1'b0) begin
                y = y / 2;
            end else if (x > y) begin
                x = x - y;
            end else begin
                y = y - x;
            end
            n++;
        end
        return n;
    endfunction

    function automatic exp_t make_exp(input int unsigned a, input int unsigned b,
                                      input int mode, input int iw);
        exp_t e;
        int   lim;
        lim     = (1 << iw) - 1;
        e.result = model_gcd(a, b);
        e.steps  = model_steps(a, b, mode);
        e.iters  = 16'((e.steps > lim) ? lim : e.steps);
        return e;
    endfunction

    // Called at a negedge; the accept edge is the next posedge.
    task automatic send(input int sel, input logic [15:0] a, input logic [15:0] b, input exp_t e);
        sb.push_back(e);
        a_in          = a;
        b_in          = b;
        in_valid[sel] = 1'b1;
        @(negedge CLK);
        in_valid[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int limit, output int lat,
                             output int busy_cnt, output bit timed_out);
        lat       = 0;
        busy_cnt  = 0;
        timed_out = 1'b0;
        while (!out_valid[sel]) begin
            if (busy[sel]) busy_cnt++;
            if (lat >= limit) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic release_out(input int sel);
        out_ready[sel] = 1'b1;
        @(negedge CLK);
        out_ready[sel] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        for (int s = 0; s < 3; s++) begin
            vectors++;
            if (in_ready[s] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reset_in_ready[%0d]: got %b expected 1", s, in_ready[s]);
            end
            vectors++;
            if (out_valid[s] !== 1'b0 || busy[s] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_valid_busy[%0d]: got %b/%b expected 0/0", s, out_valid[s], busy[s]);
            end
            vectors++;
            if (result[s] !== 16'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_result[%0d]: got %0d expected 0", s, result[s]);
            end
        end
        vectors++;
        if (iters[0] !== 16'd0 || iters[1] !== 16'd0 || iters_sat !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_iters: got %0d/%0d/%0d expected 0/0/0", iters[0], iters[1], iters_sat);
        end
        reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_compute(input int sel);
        int   rows [6][4];
        exp_t e;
        exp_t got;
        int   lat;
        int   bc;
        bit   to;
        int   a;
        int   b;
        if (sel == 0) rows = '{'{15, 32, 1, 10}, '{0, 0, 0, 0}, '{0, 42, 42, 0},
                               '{42, 42, 42, 0}, '{42, 0, 42, 0}, '{100, 75, 25, -1}};
        else          rows = '{'{48, 18, 6, -1}, '{15, 32, 1, 11}, '{65535, 65535, 65535, 0},
                               '{65534, 32768, 2, -1}, '{0, 7, 7, 0}, '{1024, 96, 32, -1}};
        for (int r = 0; r < 10; r++) begin
            if (r < 6) begin
                a = rows[r][0];
                b = rows[r][1];
            end else begin
                a = (sel == 0) ? int'($urandom_range(300, 1)) : int'($urandom_range(65535, 1));
                b = (sel == 0) ? int'($urandom_range(300, 1)) : int'($urandom_range(65535, 1));
            end
            e = make_exp(a, b, sel, 16);
            if (r < 6 && rows[r][2] >= 0) e.result = 16'(rows[r][2]);
            if (r < 6 && rows[r][3] >= 0) begin
                e.iters = 16'(rows[r][3]);
                e.steps = rows[r][3];
            end
            send(sel, 16'(a), 16'(b), e);
            wait_done(sel, e.steps + 20, lat, bc, to);
            got = sb.pop_front();
            vectors++;
            if (to) begin
                miscompares++;
                $display("[TB] FAIL compute_timeout m%0d %0d,%0d: no OutValid within %0d cycles", sel, a, b, lat);
            end
            vectors++;
            if (result[sel] !== got.result) begin
                miscompares++;
                $display("[TB] FAIL compute_result m%0d %0d,%0d: got %0d expected %0d", sel, a, b, result[sel], got.result);
            end
            vectors++;
            if (iters[sel] !== got.iters) begin
                miscompares++;
                $display("[TB] FAIL compute_iters m%0d %0d,%0d: got %0d expected %0d", sel, a, b, iters[sel], got.iters);
            end
            vectors++;
            if (lat != got.steps + 1 || bc != got.steps + 1) begin
                miscompares++;
                $display("[TB] FAIL compute_latency m%0d %0d,%0d: got %0d/busy %0d expected %0d", sel, a, b, lat, bc, got.steps + 1);
            end
            vectors++;
            if (in_ready[sel] !== 1'b0 || busy[sel] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL compute_done_flags m%0d: got ready %b busy %b expected 0/0", sel, in_ready[sel], busy[sel]);
            end
            release_out(sel);
            vectors++;
            if (out_valid[sel] !== 1'b0 || in_ready[sel] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL compute_release m%0d: got valid %b ready %b expected 0/1", sel, out_valid[sel], in_ready[sel]);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t got;
        int   lat;
        int   bc;
        bit   to;
        e = make_exp(48, 18, 0, 16);
        send(0, 16'd48, 16'd18, e);
        wait_done(0, e.steps + 20, lat, bc, to);
        got = sb.pop_front();
        vectors++;
        if (to) begin
            miscompares++;
            $display("[TB] FAIL bp_timeout: no OutValid within %0d cycles", lat);
        end
        for (int i = 0; i < 20; i++) begin
            vectors++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold_flags cycle %0d: got valid %b ready %b expected 1/0", i, out_valid[0], in_ready[0]);
            end
            vectors++;
            if (result[0] !== got.result || iters[0] !== got.iters) begin
                miscompares++;
                $display("[TB] FAIL bp_hold_data cycle %0d: got %0d/%0d expected %0d/%0d", i, result[0], iters[0], got.result, got.iters);
            end
            if (i == 5) begin
                a_in        = 16'd99;
                b_in        = 16'd3;
                in_valid[0] = 1'b1;
            end
            @(negedge CLK);
            in_valid[0] = 1'b0;
        end
        release_out(0);
        vectors++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got valid %b ready %b busy %b expected 0/1/0", out_valid[0], in_ready[0], busy[0]);
        end
        e = make_exp(12, 8, 0, 16);
        e.result = 16'd4;
        send(0, 16'd12, 16'd8, e);
        wait_done(0, e.steps + 20, lat, bc, to);
        got = sb.pop_front();
        vectors++;
        if (to || result[0] !== got.result) begin
            miscompares++;
            $display("[TB] FAIL bp_second_result: got %0d expected %0d (timeout %b)", result[0], got.result, to);
        end
        release_out(0);
    endtask

    task automatic test_reset_mid_calc();
        exp_t e;
        exp_t got;
        int   n;
        int   lat;
        int   bc;
        bit   to;
        e = make_exp(1, 65535, 0, 16);
        send(0, 16'd1, 16'd65535, e);
        n = 0;
        while (iters[0] != 16'd100 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (iters[0] !== 16'd100 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_reach: got iters %0d busy %b expected 100/1", iters[0], busy[0]);
        end
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        got = sb.pop_back();
        vectors++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_flags: got ready %b valid %b busy %b expected 1/0/0", in_ready[0], out_valid[0], busy[0]);
        end
        vectors++;
        if (result[0] !== 16'd0 || iters[0] !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL midreset_clear: got %0d/%0d expected 0/0", result[0], iters[0]);
        end
        e = make_exp(21, 14, 0, 16);
        e.result = 16'd7;
        send(0, 16'd21, 16'd14, e);
        wait_done(0, e.steps + 20, lat, bc, to);
        got = sb.pop_front();
        vectors++;
        if (to || result[0] !== got.result || iters[0] !== got.iters) begin
            miscompares++;
            $display("[TB] FAIL midreset_after: got %0d/%0d expected %0d/%0d (timeout %b)", result[0], iters[0], got.result, got.iters, to);
        end
        release_out(0);
    endtask

    task automatic test_back_to_back();
        int   ops [3][2];
        exp_t e;
        exp_t got;
        int   n;
        int   lat;
        int   bc;
        bit   to;
        int   t_acc;
        int   t_prev;
        int   prev_steps;
        ops           = '{'{48, 18}, '{15, 32}, '{100, 75}};
        t_prev        = 0;
        prev_steps    = 0;
        out_ready[1]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!in_ready[1] && n < 50) begin
                @(negedge CLK);
                n++;
            end
            e = make_exp(ops[i][0], ops[i][1], 1, 16);
            send(1, 16'(ops[i][0]), 16'(ops[i][1]), e);
            t_acc = cycle;
            if (i > 0) begin
                vectors++;
                if (t_acc - t_prev != prev_steps + 3) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_spacing op %0d: got %0d cycles expected %0d", i, t_acc - t_prev, prev_steps + 3);
                end
            end
            wait_done(1, e.steps + 20, lat, bc, to);
            got = sb.pop_front();
            vectors++;
            if (to || result[1] !== got.result) begin
                miscompares++;
                $display("[TB] FAIL b2b_result op %0d: got %0d expected %0d (timeout %b)", i, result[1], got.result, to);
            end
            t_prev     = t_acc;
            prev_steps = got.steps;
        end
        out_ready[1] = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_saturation();
        exp_t e;
        exp_t got;
        int   lat;
        e = make_exp(1, 40, 0, 4);
        e.result = 16'd1;
        e.iters  = 16'd15;
        e.steps  = 39;
        send(2, 16'd1, 16'd40, e);
        got = sb.pop_front();
        lat = 0;
        while (!out_valid[2] && lat < 100) begin
            if (lat == 14 || lat == 20) begin
                vectors++;
                if (iters_sat !== ((lat == 14) ? 4'd14 : 4'd15)) begin
                    miscompares++;
                    $display("[TB] FAIL sat_progress at %0d: got %0d expected %0d", lat, iters_sat, (lat == 14) ? 14 : 15);
                end
            end
            @(negedge CLK);
            lat++;
        end
        vectors++;
        if (lat != got.steps + 1) begin
            miscompares++;
            $display("[TB] FAIL sat_latency: got %0d expected %0d", lat, got.steps + 1);
        end
        vectors++;
        if (result[2] !== got.result || 16'(iters_sat) !== got.iters) begin
            miscompares++;
            $display("[TB] FAIL sat_final: got %0d/%0d expected %0d/%0d", result[2], iters_sat, got.result, got.iters);
        end
        release_out(2);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b0;
        end
        a_in  = 16'd0;
        b_in  = 16'd0;
        reset = 1'b1;
        test_reset();
        test_compute(0);
        test_compute(1);
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
